// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte/state sizes and the prga state encoding.
package arc4_pkg;

  localparam int unsigned S_SIZE = 256;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    SI_RD,
    SJ_RD,
    SWAP_I,
    SWAP_J,
    PAD_RD,
    PT_WR
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 keystream generator: walks S in s_ram, swaps i/j cells and XORs the pad
// into each ciphertext byte, producing a length-prefixed plaintext in pt_ram.
module prga
  import arc4_pkg::*;
#(
  parameter int unsigned MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [BYTE_W-1:0] s_addr,
  output logic [BYTE_W-1:0] s_din,
  output logic              s_wren,
  input  logic [BYTE_W-1:0] s_dout,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [BYTE_W-1:0] ct_dout,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [BYTE_W-1:0] pt_din,
  output logic              pt_wren
);

  prga_state_t state_q, state_d;

  logic [BYTE_W-1:0] i_q, i_d;
  logic [BYTE_W-1:0] j_q, j_d;
  logic [BYTE_W-1:0] si_q, si_d;
  logic [BYTE_W-1:0] sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [MSG_AW-1:0] len_q, len_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      len_q   <= len_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE:   if (en) state_d = LEN_RD;
      LEN_RD: state_d = LEN_WR;
      LEN_WR: begin
        len_d   = MSG_AW'(ct_dout);
        i_d     = BYTE_W'(1);
        j_d     = '0;
        k_d     = MSG_AW'(1);
        state_d = (ct_dout == '0) ? IDLE : SI_RD;
      end
      SI_RD:  state_d = SJ_RD;
      SJ_RD: begin
        si_d    = s_dout;
        j_d     = j_q + s_dout;
        state_d = SWAP_I;
      end
      SWAP_I: begin
        sj_d    = s_dout;
        state_d = SWAP_J;
      end
      SWAP_J: state_d = PAD_RD;
      PAD_RD: state_d = PT_WR;
      PT_WR: begin
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + BYTE_W'(1);
          k_d     = k_q + MSG_AW'(1);
          state_d = SI_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port drive; the i==j case relies on the SWAP_J write landing last
  always_comb begin
    rdy     = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    s_wren  = 1'b0;
    ct_addr = '0;
    pt_addr = '0;
    pt_din  = '0;
    pt_wren = 1'b0;
    unique case (state_q)
      IDLE:   rdy = 1'b1;
      LEN_RD: ct_addr = '0;
      LEN_WR: begin
        pt_addr = '0;
        pt_din  = ct_dout;
        pt_wren = 1'b1;
      end
      SI_RD:  s_addr = i_q;
      SJ_RD:  s_addr = j_q + s_dout;
      SWAP_I: begin
        s_addr = i_q;
        s_din  = s_dout;
        s_wren = 1'b1;
      end
      SWAP_J: begin
        s_addr = j_q;
        s_din  = si_q;
        s_wren = 1'b1;
      end
      PAD_RD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
      end
      PT_WR: begin
        pt_addr = k_q;
        pt_din  = s_dout ^ ct_dout;
        pt_wren = 1'b1;
      end
      default: rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: behavioural RC4 model feeds an expectation queue that a
// monitor drains on every pt_ram write; S contents and timing checked per run.
module tb_prga;

  localparam int unsigned MSG_AW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              rdy;
  logic [7:0]        s_addr, s_din, s_dout;
  logic              s_wren;
  logic [MSG_AW-1:0] ct_addr, pt_addr;
  logic [7:0]        ct_dout, pt_din;
  logic              pt_wren;

  logic [7:0] s_mem   [256];
  logic [7:0] ct_mem  [256];
  logic [7:0] pt_mem  [256];
  logic [7:0] s_img   [256];
  logic [7:0] s_model [256];
  logic       load_s = 1'b0;
  logic [7:0] key [$];

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t q[$];

  int total  = 0;
  int bad    = 0;
  int sw_cnt = 0;
  int pw_cnt = 0;

  prga #(.MSG_AW(MSG_AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rdy     (rdy),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_wren  (s_wren),
    .s_dout  (s_dout),
    .ct_addr (ct_addr),
    .ct_dout (ct_dout),
    .pt_addr (pt_addr),
    .pt_din  (pt_din),
    .pt_wren (pt_wren)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; load_s copies a prepared image into S
  always @(posedge clk) begin
    if (load_s) s_mem <= s_img;
    else if (s_wren) s_mem[s_addr] <= s_din;
    s_dout  <= s_mem[s_addr];
    ct_dout <= ct_mem[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_din;
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (s_wren) sw_cnt++;
      if (s_wren || pt_wren) check("wren_exclusive", int'(s_wren & pt_wren), 0);
      if (pt_wren) begin
        pw_cnt++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pt_unexpected: write addr %0d data %0d with nothing expected",
                   pt_addr, pt_din);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pt_addr", int'(pt_addr), e.addr);
          check("pt_data", int'(pt_din), e.data);
        end
      end
    end
  end

  task automatic identity_img();
    for (int i = 0; i < 256; i++) s_img[i] = 8'(i);
  endtask

  task automatic ksa_img();
    int j;
    logic [7:0] t;
    identity_img();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s_img[i]) + int'(key[i % key.size()])) % 256;
      t = s_img[i];
      s_img[i] = s_img[j];
      s_img[j] = t;
    end
  endtask

  task automatic shuffle_img();
    int r;
    logic [7:0] t;
    identity_img();
    for (int i = 255; i > 0; i--) begin
      r = $urandom_range(0, i);
      t = s_img[i];
      s_img[i] = s_img[r];
      s_img[r] = t;
    end
  endtask

  // Called at a negedge while the DUT is idle
  task automatic load_s_mem();
    s_model = s_img;
    load_s  = 1'b1;
    @(negedge clk);
    load_s  = 1'b0;
  endtask

  task automatic random_ct(input int len);
    ct_mem[0] = 8'(len);
    for (int k = 1; k <= len; k++) ct_mem[k] = 8'($urandom_range(0, 255));
  endtask

  // Reference RC4 decrypt over ct_mem; each run restarts at i=0,j=0 (first byte uses i=1)
  task automatic model_run();
    int len, i, j, pad;
    logic [7:0] t;
    len = int'(ct_mem[0]);
    q.push_back('{0, len});
    i = 0;
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(s_model[i])) % 256;
      t = s_model[i];
      s_model[i] = s_model[j];
      s_model[j] = t;
      pad = int'(s_model[(int'(s_model[i]) + int'(s_model[j])) % 256]);
      q.push_back('{k, int'(ct_mem[k]) ^ pad});
    end
  endtask

  task automatic run(output int cyc);
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    if (!rdy) check("rdy_timeout", 0, 1);
  endtask

  task automatic check_s(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) if (s_mem[i] !== s_model[i]) n++;
    check(name, n, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int cyc, cyc2, n, guard, sw0, pw0, len;
    string pt_str;

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_rdy", int'(rdy), 1);
    check("rst_s_wren", int'(s_wren), 0);
    check("rst_pt_wren", int'(pt_wren), 0);
    check("rst_s_addr", int'(s_addr), 0);
    check("rst_ct_addr", int'(ct_addr), 0);
    check("rst_pt_addr", int'(pt_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity S, three zero ciphertext bytes
    ct_mem[0] = 8'd3; ct_mem[1] = 8'd0; ct_mem[2] = 8'd0; ct_mem[3] = 8'd0;
    identity_img();
    load_s_mem();
    model_run();
    run(cyc);
    check("ident_cycles", cyc, 20);
    check("ident_pt0", int'(pt_mem[0]), 3);
    check("ident_pt1", int'(pt_mem[1]), 2);
    check("ident_pt2", int'(pt_mem[2]), 5);
    check("ident_pt3", int'(pt_mem[3]), 7);
    check("ident_s2", int'(s_mem[2]), 3);
    check("ident_q_empty", q.size(), 0);
    check_s("ident_s_state");

    // Known vector: key "Key", plaintext "Plaintext"
    key.delete();
    key.push_back(8'h4B); key.push_back(8'h65); key.push_back(8'h79);
    ct_mem[0] = 8'h09; ct_mem[1] = 8'hBB; ct_mem[2] = 8'hF3; ct_mem[3] = 8'h16;
    ct_mem[4] = 8'hE8; ct_mem[5] = 8'hD9; ct_mem[6] = 8'h40; ct_mem[7] = 8'hAF;
    ct_mem[8] = 8'h0A; ct_mem[9] = 8'hD3;
    ksa_img();
    load_s_mem();
    model_run();
    run(cyc);
    check("key_cycles", cyc, 56);
    check("key_pt_len", int'(pt_mem[0]), 9);
    pt_str = "Plaintext";
    n = 0;
    for (int k = 1; k <= 9; k++) if (pt_mem[k] !== pt_str[k-1]) n++;
    check("key_plaintext_bytes_wrong", n, 0);
    check("key_q_empty", q.size(), 0);
    check_s("key_s_state");

    // Zero-length message
    ct_mem[0] = 8'd0;
    sw0 = sw_cnt;
    pw0 = pw_cnt;
    model_run();
    run(cyc);
    check("len0_cycles", cyc, 2);
    check("len0_s_writes", sw_cnt - sw0, 0);
    check("len0_pt_writes", pw_cnt - pw0, 1);
    check("len0_pt0", int'(pt_mem[0]), 0);
    check("len0_q_empty", q.size(), 0);
    check_s("len0_s_state");

    // Reset during SWAP_I of byte 2, then a clean rerun
    random_ct(5);
    ksa_img();
    load_s_mem();
    model_run();
    pw0 = pw_cnt;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 0;
    guard = 0;
    while (guard < 200) begin
      if (s_wren) n++;
      if (n == 3) break;
      @(negedge clk);
      guard++;
    end
    check("abort_reached_swap_i", n, 3);
    rst = 1'b1;
    #1;
    check("abort_rdy", int'(rdy), 1);
    check("abort_s_wren", int'(s_wren), 0);
    check("abort_pt_wren", int'(pt_wren), 0);
    check("abort_pt_writes_before", pw_cnt - pw0, 2);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    sw0 = sw_cnt;
    pw0 = pw_cnt;
    repeat (10) @(negedge clk);
    check("abort_idle_s_writes", sw_cnt - sw0, 0);
    check("abort_idle_pt_writes", pw_cnt - pw0, 0);
    check("abort_idle_rdy", int'(rdy), 1);
    ksa_img();
    load_s_mem();
    model_run();
    run(cyc);
    check("rerun_cycles", cyc, 32);
    check("rerun_q_empty", q.size(), 0);
    check_s("rerun_s_state");

    // en held high: two chained runs over the same ciphertext
    key.delete();
    key.push_back(8'h53); key.push_back(8'h65); key.push_back(8'h63);
    key.push_back(8'h72); key.push_back(8'h65); key.push_back(8'h74);
    random_ct(6);
    ksa_img();
    load_s_mem();
    model_run();
    model_run();
    en = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!rdy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    check("chain_run1_cycles", cyc, 38);
    check("chain_rdy_high", int'(rdy), 1);
    @(negedge clk);
    check("chain_restart", int'(rdy), 0);
    en = 1'b0;
    cyc2 = 1;
    @(negedge clk);
    while (!rdy && cyc2 < 5000) begin
      cyc2++;
      @(negedge clk);
    end
    check("chain_run2_cycles", cyc2, 38);
    check("chain_q_empty", q.size(), 0);
    check_s("chain_s_state");

    // Random S permutations and messages, including the maximum length
    for (int r = 0; r < 4; r++) begin
      len = (r == 0) ? 255 : int'($urandom_range(1, 40));
      random_ct(len);
      shuffle_img();
      load_s_mem();
      model_run();
      run(cyc);
      check("rand_cycles", cyc, 2 + 6 * len);
      check("rand_q_empty", q.size(), 0);
      check_s("rand_s_state");
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
